// File: rtl/regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_alu_pipe
//  Description : 2-stage pipeline. A register file feeds a registered ALU
//                stage, with a write-back bypass into operand capture.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             wr,
    input  logic             sel,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic [WIDTH-1:0] alu_out,
    output logic             cout,
    output logic             zero,
    output logic             out_valid
);

    localparam int         C_DEPTH  = 1 << AW;
    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_OR  = 3'b011;
    localparam logic [2:0] C_OP_XOR = 3'b100;
    localparam logic [2:0] C_OP_NOT = 3'b101;
    localparam logic [2:0] C_OP_SHL = 3'b110;

    logic [WIDTH-1:0] rf_q [C_DEPTH];

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, din_q, din_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic             sel_q, sel_d, wr_q, wr_d, valid_q, valid_d;

    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_res, w_wdata;
    logic             w_carry, w_we;

    // Stage 2: ALU on the registered operands
    always_comb begin
        w_sum   = {1'b0, a_q} + {1'b0, b_q};
        w_diff  = {1'b0, a_q} - {1'b0, b_q};
        w_res   = '0;
        w_carry = 1'b0;
        case (op_q)
            C_OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
            C_OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
            C_OP_AND: w_res = a_q & b_q;
            C_OP_OR:  w_res = a_q | b_q;
            C_OP_XOR: w_res = a_q ^ b_q;
            C_OP_NOT: w_res = ~a_q;
            C_OP_SHL: begin w_res = {a_q[WIDTH-2:0], 1'b0}; w_carry = a_q[WIDTH-1]; end
            default:  begin w_res = {1'b0, a_q[WIDTH-1:1]}; w_carry = a_q[0];       end
        endcase
    end

    assign w_we    = valid_q & wr_q;
    assign w_wdata = sel_q ? w_res : din_q;

    // Stage 1: capture with bypass of the write retiring on this same edge
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sel_d   = sel_q;
        waddr_d = waddr_q;
        din_d   = din_q;
        wr_d    = 1'b0;
        valid_d = in_valid;
        if (in_valid) begin
            a_d     = (w_we && waddr_q == rd_addr_a) ? w_wdata : rf_q[rd_addr_a];
            b_d     = (w_we && waddr_q == rd_addr_b) ? w_wdata : rf_q[rd_addr_b];
            op_d    = op;
            sel_d   = sel;
            wr_d    = wr;
            waddr_d = wr_addr;
            din_d   = d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C_DEPTH; i++) rf_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (w_we) rf_q[waddr_q] <= w_wdata;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            valid_q <= valid_d;
        end
    end

    assign d_out_a   = a_q;
    assign d_out_b   = b_q;
    assign alu_out   = w_res;
    assign cout      = w_carry;
    assign zero      = (w_res == '0);
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/regfile_alu_pipe.md
REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, sets the data width of every register, operand and result.
REQ-002 Parameter AW, default 3, sets the register address width; DEPTH = 2^AW registers.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 in_valid  input  1  instruction present this cycle; 0 inserts a bubble.
REQ-006 wr  input  1  instruction writes back to the register file.
REQ-007 sel  input  1  write-back source: 1 = ALU result, 0 = d_in.
REQ-008 op  input  3  ALU operation code.
REQ-009 rd_addr_a  input  AW  operand A register address.
REQ-010 rd_addr_b  input  AW  operand B register address.
REQ-011 wr_addr  input  AW  write-back register address.
REQ-012 d_in  input  WIDTH  external write data.
REQ-013 d_out_a  output  WIDTH  stage-2 operand A, registered.
REQ-014 d_out_b  output  WIDTH  stage-2 operand B, registered.
REQ-015 alu_out  output  WIDTH  ALU result computed from stage-2 operands.
REQ-016 cout  output  1  carry, borrow or shifted-out bit of the current result.
REQ-017 zero  output  1  1 when alu_out == 0.
REQ-018 out_valid  output  1  stage-2 holds a valid instruction.

Function
REQ-019 Register file SHALL be DEPTH x WIDTH, with two read ports and one write port; every register, including register 0, SHALL be writable.
REQ-020 Stage 1: on the rising edge where in_valid=1, the block SHALL capture operands A/B (after bypass), op, sel, wr, wr_addr and d_in into stage-2 registers; out_valid SHALL then be 1.
REQ-021 Stage 1: on the rising edge where in_valid=0, out_valid SHALL be 0 and the captured wr SHALL be forced to 0.
REQ-022 Stage 2 SHALL compute alu_out, cout and zero combinationally from the stage-2 registers; latency is 1 cycle from acceptance to a valid result.
REQ-023 Write-back SHALL occur on the edge that ends stage 2, only when out_valid=1 and stage-2 wr=1.
REQ-024 Write data SHALL be alu_out when sel=1 and stage-2 d_in when sel=0.
REQ-025 Bypass: when a stage-2 write targets rd_addr_a or rd_addr_b in the same cycle, the captured operand SHALL be the write data, not the stale register contents.
REQ-026 op 000 ADD: A+B; cout = carry out of the MSB.
REQ-027 op 001 SUB: A-B modulo 2^WIDTH; cout = 1 when A<B (unsigned borrow).
REQ-028 op 010 AND, 011 OR, 100 XOR, 101 NOT A: bitwise operations; cout = 0.
REQ-029 op 110 SHL: A<<1; cout = A[WIDTH-1].
REQ-030 op 111 SHR: logical A>>1; cout = A[0].
REQ-031 When wr=0, wr_addr and sel SHALL be don't-care and no register SHALL change.
REQ-032 When out_valid=0, alu_out, cout and zero SHALL be don't-care and SHALL cause no side effects.

Reset
REQ-033 While reset=0, all registers, stage-2 state, d_out_a, d_out_b and out_valid SHALL be 0; alu_out SHALL be 0, zero=1 and cout=0.
REQ-034 Reset asserted mid-pipeline SHALL discard the pending write-back; no register SHALL take the in-flight data.
REQ-035 The first instruction SHALL be accepted on the first rising edge after reset returns to 1.

Verification (WIDTH=16, AW=3)
REQ-036 Release reset, then read every address pair -> d_out_a = d_out_b = 0000, out_valid = 1 only for valid reads.
REQ-037 Write R3=cdef and R7=3210 (sel=0), then issue ADD R3,R7 -> R5 with sel=1 -> alu_out=ffff, cout=0, zero=0; a later read of R5 returns ffff.
REQ-038 Write R1=ba98, then immediately issue SUB R1,R1 -> R6 (back-to-back, bypass) -> d_out_a = d_out_b = ba98, alu_out=0000, zero=1, cout=0.
REQ-039 With R2=ffff and R4=0001: ADD R2,R4 -> alu_out=0000, cout=1, zero=1; SHR R4 -> 0000, cout=1; SHL R2 -> fffe, cout=1.
REQ-040 Write R0=1234 with in_valid=0 -> R0 stays 0000; assert reset during a valid write to R2 -> R2 reads 0000 and out_valid=0 immediately, without waiting for a clock edge.
